// File: rtl/mcp42000_pkg.sv
// Shared types and constants for the MCP42000-style SPI digipot responder.
// Define MCP42000_DAISY_EN to enable daisy-chain serial out and multi-word frames.
`timescale 1ns/1ps
package mcp42000_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

`ifdef MCP42000_DAISY_EN
  localparam bit DAISY_EN = 1'b1;
`else
  localparam bit DAISY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    CMD_NOP0  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_SHDN  = 2'b10,
    CMD_NOP1  = 2'b11
  } cmd_e;

  localparam logic [1:0] POT_NONE = 2'b00;
  localparam logic [1:0] POT_0    = 2'b01;
  localparam logic [1:0] POT_1    = 2'b10;
  localparam logic [1:0] POT_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_e;

  // Daisy chains accept any whole number of words; the last word shifted in is ours.
  function automatic logic frame_valid(input logic [CNT_W-1:0] cnt);
    if (DAISY_EN)
      return (cnt != '0) && (cnt[3:0] == 4'd0) && (cnt < CNT_MAX);
    else
      return cnt == CNT_W'(FRAME_BITS);
  endfunction

endpackage

// File: rtl/mcp42000_spi_responder_if.sv
// SPI bus between a master and the MCP42000 responder.
`timescale 1ns/1ps
interface mcp42000_spi_responder_if;
  logic sck;
  logic cs;
  logic mosi;
  logic so;

  modport master (output sck, output cs, output mosi, input so);
  modport slave  (input sck, input cs, input mosi, output so);
endinterface

// File: rtl/mcp42000_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall pulses on the synced copy.
`timescale 1ns/1ps
module mcp42000_sync_edge #(
  parameter int STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              q_d;

  // NOTE: all sequential state uses non-blocking assignments so flop order never matters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      q_d  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      q_d  <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/mcp42000_spi_responder.sv
// SPI-slave register model of a dual digital potentiometer (MCP42xxx command set).
// Optional daisy-chain support is enabled with MCP42000_DAISY_EN.
`timescale 1ns/1ps
module mcp42000_spi_responder
  import mcp42000_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] WIPER_RESET = 8'h80
) (
  input  logic                      clk,
  input  logic                      reset,
  mcp42000_spi_responder_if.slave   spi,
  output logic [7:0]                wiper0,
  output logic [7:0]                wiper1,
  output logic [1:0]                shdn,
  output logic                      frame_done,
  output logic                      frame_err
);

  logic sck_rise, sck_fall, sck_s;
  logic cs_rise, cs_fall, cs_s;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  mcp42000_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .reset(reset), .d(spi.sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  mcp42000_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .reset(reset), .d(spi.cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  // Same depth as sck so mosi is aligned with the detected sck edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  state_e                state;
  logic [FRAME_BITS-1:0] sr;
  logic [CNT_W-1:0]      cnt;
  logic                  so_q;
  cmd_e                  cmd;
  logic [1:0]            pot_sel;

  assign cmd     = cmd_e'(sr[13:12]);
  assign pot_sel = sr[9:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      wiper0     <= WIPER_RESET;
      wiper1     <= WIPER_RESET;
      shdn       <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // cs release wins over a coincident sck edge.
          if (cs_rise) begin
            state <= DECODE;
          end else if (sck_rise) begin
            sr <= {sr[FRAME_BITS-2:0], mosi_s};
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        DECODE: begin
          state <= IDLE;
          if (frame_valid(cnt)) begin
            frame_done <= 1'b1;
            if (cmd == CMD_WRITE) begin
              if (pot_sel[0]) begin wiper0 <= sr[7:0]; shdn[0] <= 1'b0; end
              if (pot_sel[1]) begin wiper1 <= sr[7:0]; shdn[1] <= 1'b0; end
            end else if (cmd == CMD_SHDN) begin
              if (pot_sel[0]) shdn[0] <= 1'b1;
              if (pot_sel[1]) shdn[1] <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Daisy-chain out: the word being pushed out of sr[15] trails the input by 16 sck periods.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     so_q <= 1'b0;
    else if (!DAISY_EN || cs_s)    so_q <= 1'b0;
    else if (sck_fall)             so_q <= sr[FRAME_BITS-1];
  end

  assign spi.so = so_q;

endmodule

// File: tb/tb_mcp42000_spi_responder.sv
// Self-checking bench for mcp42000_spi_responder: directed spec frames plus random frames
// checked against a command-level model of the two pots.
`timescale 1ns/1ps
module tb_mcp42000_spi_responder;
  import mcp42000_pkg::*;

  localparam int         HALF        = 20;
  localparam int         SYNC        = 2;
  localparam logic [7:0] WIPER_RESET = 8'h80;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wiper0, wiper1;
  logic [1:0] shdn;
  logic       frame_done, frame_err;

  always #5 clk = ~clk;

  mcp42000_spi_responder_if spi ();

  mcp42000_spi_responder #(.SYNC_STAGES(SYNC), .WIPER_RESET(WIPER_RESET)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi        (spi.slave),
    .wiper0     (wiper0),
    .wiper1     (wiper1),
    .shdn       (shdn),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  int errors = 0;
  int checks = 0;
  int done_seen = 0, err_seen = 0, both_seen = 0;

  always @(negedge clk) begin
    if (frame_done) done_seen++;
    if (frame_err)  err_seen++;
    if (frame_done && frame_err) both_seen++;
  end

  // Reference model: pot state as seen from the command protocol.
  logic [7:0] m_wiper [2];
  logic [1:0] m_shdn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wiper[0] = WIPER_RESET;
    m_wiper[1] = WIPER_RESET;
    m_shdn     = 2'b00;
  endtask

  // Returns 1 if the frame should be accepted; applies its effect to the model.
  task automatic model_frame(input logic [63:0] data, input int n, output bit ok);
    logic [15:0] f;
`ifdef MCP42000_DAISY_EN
    ok = (n > 0) && (n % 16 == 0) && (n < 63);
`else
    ok = (n == 16);
`endif
    f = data[15:0];
    if (ok) begin
      for (int p = 0; p < 2; p++) begin
        if (f[8+p]) begin
          if (f[13:12] == 2'd1) begin
            m_wiper[p] = f[7:0];
            m_shdn[p]  = 1'b0;
          end else if (f[13:12] == 2'd2) begin
            m_shdn[p] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic send_bit(input logic b);
    spi.mosi = b;
    wait_clk(HALF);
    spi.sck = 1'b1;
    wait_clk(HALF);
    spi.sck = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [63:0] data, input int n, input bit chk_so);
    int d0, e0;
    bit ok;
    d0 = done_seen;
    e0 = err_seen;
    model_frame(data, n, ok);
    spi.cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < n; i++) begin
`ifdef MCP42000_DAISY_EN
      if (chk_so && i >= 16) begin
        spi.mosi = data[n-1-i];
        wait_clk(HALF);
        check({tag, ".so"}, 32'(spi.so), 32'(data[n-1-(i-16)]));
        spi.sck = 1'b1;
        wait_clk(HALF);
        spi.sck = 1'b0;
      end else
`endif
        send_bit(data[n-1-i]);
    end
    wait_clk(HALF);
    spi.cs = 1'b1;
    wait_clk(HALF);
    check({tag, ".done"},   32'(done_seen - d0), ok ? 32'd1 : 32'd0);
    check({tag, ".err"},    32'(err_seen - e0),  ok ? 32'd0 : 32'd1);
    check({tag, ".wiper0"}, 32'(wiper0), 32'(m_wiper[0]));
    check({tag, ".wiper1"}, 32'(wiper1), 32'(m_wiper[1]));
    check({tag, ".shdn"},   32'(shdn),   32'(m_shdn));
  endtask

  initial begin
    int d0, e0, n;
    logic [63:0] data;

    reset    = 1'b1;
    spi.sck  = 1'b0;
    spi.cs   = 1'b1;
    spi.mosi = 1'b0;
    model_reset();
    wait_clk(3);
    check("rst.wiper0", 32'(wiper0), 32'h80);
    check("rst.wiper1", 32'(wiper1), 32'h80);
    check("rst.shdn",   32'(shdn), 32'h0);
    check("rst.done",   32'(frame_done), 32'h0);
    check("rst.err",    32'(frame_err), 32'h0);
    check("rst.so",     32'(spi.so), 32'h0);
    reset = 1'b0;
    wait_clk(10);
    check("post_rst.pulses", 32'(done_seen + err_seen), 32'h0);

    run_frame("f1137", 64'h1137, 16, 1'b0);
    check("f1137.w0_const", 32'(wiper0), 32'h37);
    check("f1137.w1_const", 32'(wiper1), 32'h80);

    run_frame("f13A5", 64'h13A5, 16, 1'b0);
    check("f13A5.w0_const", 32'(wiper0), 32'hA5);
    check("f13A5.w1_const", 32'(wiper1), 32'hA5);
    run_frame("f2200", 64'h2200, 16, 1'b0);
    check("f2200.shdn_const", 32'(shdn), 32'h2);
    check("f2200.w1_const",   32'(wiper1), 32'hA5);
    run_frame("f1210", 64'h1210, 16, 1'b0);
    check("f1210.w1_const",   32'(wiper1), 32'h10);
    check("f1210.shdn_const", 32'(shdn), 32'h0);

    run_frame("short12", 64'h1BCD, 12, 1'b0);
    run_frame("long17",  64'h1_13FF, 17, 1'b0);
    check("long17.w0_const", 32'(wiper0), 32'hA5);

    // Reset in the middle of a frame: the partial frame must vanish silently.
    spi.cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 8; i++) send_bit(1'(i & 1));
    reset = 1'b1;
    model_reset();
    wait_clk(3);
    check("midrst.wiper1", 32'(wiper1), 32'h80);
    check("midrst.shdn",   32'(shdn), 32'h0);
    d0 = done_seen;
    e0 = err_seen;
    reset = 1'b0;
    wait_clk(HALF);
    spi.cs = 1'b1;
    wait_clk(3 * HALF);
    check("midrst.no_pulse", 32'((done_seen - d0) + (err_seen - e0)), 32'h0);
    run_frame("f1155", 64'h1155, 16, 1'b0);
    check("f1155.w0_const", 32'(wiper0), 32'h55);

    for (int k = 0; k < 24; k++) begin
      data = {$urandom, $urandom};
      data[13:12] = ($urandom_range(0, 3) != 0) ? 2'(1 + $urandom_range(0, 1)) : 2'($urandom);
      case ($urandom_range(0, 7))
        0:       n = $urandom_range(1, 40);
        1:       n = 32;
        default: n = 16;
      endcase
      run_frame($sformatf("rand%0d", k), data, n, 1'b0);
    end

`ifdef MCP42000_DAISY_EN
    run_frame("daisy", {32'h0, 16'h1137, 16'h1142}, 32, 1'b1);
    check("daisy.w0_const", 32'(wiper0), 32'h42);
    check("daisy.so_idle",  32'(spi.so), 32'h0);
`else
    check("nodaisy.so", 32'(spi.so), 32'h0);
`endif

    check("exclusive_pulses", 32'(both_seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
